uart_rx_bit_ctrl: RTL and testbench
===================================

// Module: uart_rx_bit_ctrl
// PURPOSE
//  Receive-side bit controller that sits directly upstream of the receive shift register.
//  It synchronises the asynchronous rx line and detects a start bit using an oversampling tick.
//  It samples each bit at mid-bit and issues one serial bit plus one shift strobe per data bit.
//  It then checks the optional parity bit and the stop bit, and flags frame completion and errors.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..8); exactly this many data_shift pulses per good start
//  OVERSAMPLE  16  tick pulses per bit period; even, >=8
//  PARITY_EN   0   1 = a parity bit follows the data bits
//  PARITY_ODD  0   1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  tick        in   1  one-clk enable at OVERSAMPLE x baud; all bit timing counts these
//  rx          in   1  asynchronous serial line, idle high
//  bit_out     out  1  sampled data bit, valid while data_shift=1
//  data_shift  out  1  one-clk strobe: downstream shifts in bit_out
//  frame_done  out  1  one-clk strobe at mid-stop-bit of every frame that passed start validation
//  frame_err   out  1  stop bit sampled low; valid with frame_done, held until next frame_done
//  parity_err  out  1  parity mismatch; valid with frame_done, held until next frame_done
//  busy        out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; synchroniser flops = 1; state IDLE; counters 0. Reset mid-frame aborts
//   immediately with no further strobes.
//  rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s and act only on
//   clk edges with tick=1; in non-tick cycles state and counters hold.
//  scnt counts ticks within a bit, width clog2(OVERSAMPLE). bcnt counts data bits, width clog2(DATA_BITS+1).
//  IDLE: rx_s=0 on a tick -> START, scnt=0.
//  START: scnt++. At scnt==OVERSAMPLE/2-1, the mid-start point:
//   - rx_s=0 -> DATA, scnt=0, bcnt=0, par=PARITY_ODD.
//   - rx_s=1 -> IDLE; this is a glitch, and no strobe of any kind is issued.
//  DATA: scnt++. At scnt==OVERSAMPLE-1, the mid-bit point:
//   - on the next edge, bit_out<=rx_s and data_shift<=1 for exactly 1 clk;
//   - par^=rx_s; bcnt++; scnt=0.
//   - After the DATA_BITS-th bit: go to PARITY if PARITY_EN=1, else STOP.
//   - Bits are emitted in line order: first bit on the wire comes out first.
//  PARITY: at mid-bit, parity_err_next = rx_s ^ par. No data_shift. -> STOP.
//  STOP: at mid-bit, frame_done<=1 for 1 clk. frame_err<=~rx_s; parity_err updates (0 if PARITY_EN=0).
//   - rx_s=1 -> IDLE: a new start can be detected from the next tick onward.
//   - rx_s=0 -> BREAK.
//  BREAK: wait for rx_s=1 on a tick -> IDLE. A low line is never treated as a new start.
//  data_shift, frame_done and parity/stop sampling are never simultaneous.
//   Minimum spacing between data_shift pulses is OVERSAMPLE ticks.
//  Latency: a strobe is asserted in the clk cycle after the tick edge at the sample point.
//   Start edge to first data_shift is 1.5 bit periods plus 2 clks of synchroniser delay.
//  tick held high continuously is legal; the block then treats clk as the oversample clock.
// TESTING
//  1 Defaults, tick every 4 clks, frame 0xA5 LSB-first, stop=1 ->
//    8 data_shift pulses, bit_out sequence 1,0,1,0,0,1,0,1;
//    pulses spaced 64 clks; frame_done=1 with frame_err=0.
//  2 rx low for 3 ticks then high (glitch) -> no data_shift, no frame_done; busy returns to 0;
//    next valid frame 0x3C is received correctly.
//  3 Frame 0x55 with stop bit driven 0, line held low 2 bit times ->
//    frame_err=1 at frame_done; busy stays 1 until rx high;
//    no new start is detected while low.
//  4 PARITY_EN=1, PARITY_ODD=0:
//    - 0x07 with parity bit 1 -> parity_err=0;
//    - 0x07 with parity bit 0 -> parity_err=1;
//    - both cases give exactly 8 data_shift pulses.
//  5 Assert rst after the 4th data_shift of a frame ->
//    all outputs 0 in the same cycle, no further strobes;
//    a frame sent after release is received with 8 pulses.
//  6 Back-to-back frames 0xFF, 0x00 with no idle gap -> 16 data_shift pulses, 2 frame_done,
//    no errors.

Source files
------------

// File: rtl/uart_rx_bit_ctrl.sv
// UART receive bit controller: synchronises rx, finds the start bit, samples every bit at mid-bit.
// Strobes appear one clk after the sample tick edge; there is no backpressure, so downstream must take every data_shift.
module uart_rx_bit_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic rx,
  output logic bit_out,
  output logic data_shift,
  output logic frame_done,
  output logic frame_err,
  output logic parity_err,
  output logic busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic          rx_m;
  logic          rx_s;
  logic [2:0]    state;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic          par;
  logic          par_err_q;

  // Synchroniser flops come out of reset high so an idle line never looks like a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      scnt       <= '0;
      bcnt       <= '0;
      par        <= 1'b0;
      par_err_q  <= 1'b0;
      bit_out    <= 1'b0;
      data_shift <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      data_shift <= 1'b0;
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state <= S_START;
              scnt  <= '0;
            end
          end
          S_START: begin
            if (scnt == MID_START) begin
              if (!rx_s) begin
                state <= S_DATA;
                scnt  <= '0;
                bcnt  <= '0;
                par   <= 1'(PARITY_ODD);
              end else begin
                state <= S_IDLE;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          S_DATA: begin
            if (scnt == MID_BIT) begin
              bit_out    <= rx_s;
              data_shift <= 1'b1;
              par        <= par ^ rx_s;
              bcnt       <= bcnt + 1'b1;
              scnt       <= '0;
              if (bcnt == LAST_BIT)
                state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (scnt == MID_BIT) begin
              par_err_q <= rx_s ^ par;
              scnt      <= '0;
              state     <= S_STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          S_STOP: begin
            if (scnt == MID_BIT) begin
              frame_done <= 1'b1;
              frame_err  <= ~rx_s;
              parity_err <= (PARITY_EN != 0) & par_err_q;
              scnt       <= '0;
              state      <= rx_s ? S_IDLE : S_BREAK;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          S_BREAK: begin
            // A held-low line is a break, not a new start; wait for it to go idle.
            if (rx_s)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_bit_ctrl.sv
// Bench for uart_rx_bit_ctrl: a default instance plus an even-parity instance driven with directed frames.
module tb_uart_rx_bit_ctrl;

  localparam int BIT_CLKS = 64;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic tick = 1'b0;
  logic rx0  = 1'b1;
  logic rx1  = 1'b1;
  logic bo0, ds0, fd0, fe0, pe0, bz0;
  logic bo1, ds1, fd1, fe1, pe1, bz1;
  logic [1:0] bo, ds, fd, fe, pe;

  assign bo = {bo1, bo0};
  assign ds = {ds1, ds0};
  assign fd = {fd1, fd0};
  assign fe = {fe1, fe0};
  assign pe = {pe1, pe0};

  uart_rx_bit_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx0),
    .bit_out(bo0), .data_shift(ds0), .frame_done(fd0),
    .frame_err(fe0), .parity_err(pe0), .busy(bz0)
  );

  uart_rx_bit_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx1),
    .bit_out(bo1), .data_shift(ds1), .frame_done(fd1),
    .frame_err(fe1), .parity_err(pe1), .busy(bz1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 4 clks.
  initial forever begin
    @(negedge clk);
    tick = (cyc % 4 == 0);
  end

  typedef struct {
    int   inst;
    int   kind;  // 0 = data bit, 1 = frame end
    logic b;
    int   idx;
    logic fe;
    logic pe;
  } ev_t;

  ev_t        expq[$];
  int         checks = 0;
  int         errors = 0;
  int         ds_cnt [2];
  int         fd_cnt [2];
  int         last_ds[2];
  int         tstart [2];
  logic [7:0] cap    [2];
  logic       last_fe[2];
  logic       last_pe[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: every data_shift / frame_done is matched against the expected event queue.
  initial begin
    for (int i = 0; i < 2; i++) begin
      ds_cnt[i] = 0; fd_cnt[i] = 0; last_ds[i] = 0; tstart[i] = 0;
      cap[i] = 8'h00; last_fe[i] = 1'b0; last_pe[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ds[i] || fd[i]) chk("strobe_overlap", int'(ds[i] & fd[i]), 0);
        if (ds[i]) begin
          ds_cnt[i]++;
          cap[i] = {cap[i][6:0], bo[i]};
          chk("pending_event_at_shift", int'(expq.size() > 0), 1);
          if (expq.size() > 0) begin
            ev_t e;
            int lat;
            e = expq.pop_front();
            chk("shift_inst", i, e.inst);
            chk("shift_kind", 0, e.kind);
            chk("shift_bit", int'(bo[i]), int'(e.b));
            if (e.idx == 0) begin
              lat = cyc - tstart[i];
              checks++;
              if (lat < 99 || lat > 102) begin
                errors++;
                $display("FAIL first_shift_latency: got %0d clks expected 99..102", lat);
              end
            end else begin
              chk("shift_spacing", cyc - last_ds[i], BIT_CLKS);
            end
          end
          last_ds[i] = cyc;
        end
        if (fd[i]) begin
          fd_cnt[i]++;
          last_fe[i] = fe[i];
          last_pe[i] = pe[i];
          chk("pending_event_at_done", int'(expq.size() > 0), 1);
          if (expq.size() > 0) begin
            ev_t e;
            e = expq.pop_front();
            chk("done_inst", i, e.inst);
            chk("done_kind", 1, e.kind);
            chk("frame_err", int'(fe[i]), int'(e.fe));
            chk("parity_err", int'(pe[i]), int'(e.pe));
          end
        end
      end
    end
  end

  task automatic drive(input int sel, input logic v, input int clks);
    if (sel == 0) rx0 = v; else rx1 = v;
    repeat (clks) @(negedge clk);
  endtask

  // Model: bits come out LSB first; frame_err = !stop; even parity error = xor(data, parity bit).
  task automatic send(input int sel, input logic [7:0] d, input bit has_par,
                      input bit pbit, input bit stop, input int stop_clks);
    ev_t e;
    for (int i = 0; i < 8; i++) begin
      e.inst = sel; e.kind = 0; e.b = d[i]; e.idx = i; e.fe = 1'b0; e.pe = 1'b0;
      expq.push_back(e);
    end
    e.inst = sel; e.kind = 1; e.b = 1'b0; e.idx = 8;
    e.fe = ~stop;
    e.pe = has_par ? ((^d) ^ pbit) : 1'b0;
    expq.push_back(e);
    tstart[sel] = cyc;
    drive(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLKS);
    if (has_par) drive(sel, pbit, BIT_CLKS);
    drive(sel, stop, stop_clks);
  endtask

  int b_ds, b_fd, n;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bit_out0", int'(bo0), 0);    chk("rst_shift0", int'(ds0), 0);
    chk("rst_done0", int'(fd0), 0);       chk("rst_ferr0", int'(fe0), 0);
    chk("rst_perr0", int'(pe0), 0);       chk("rst_busy0", int'(bz0), 0);
    chk("rst_bit_out1", int'(bo1), 0);    chk("rst_shift1", int'(ds1), 0);
    chk("rst_done1", int'(fd1), 0);       chk("rst_ferr1", int'(fe1), 0);
    chk("rst_perr1", int'(pe1), 0);       chk("rst_busy1", int'(bz1), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: 0xA5, good stop
    b_ds = ds_cnt[0]; b_fd = fd_cnt[0];
    send(0, 8'hA5, 0, 0, 1, BIT_CLKS);
    repeat (40) @(negedge clk);
    chk("t1_shifts", ds_cnt[0] - b_ds, 8);
    chk("t1_done", fd_cnt[0] - b_fd, 1);
    chk("t1_bits", int'(cap[0]), int'(8'b1010_0101));
    chk("t1_ferr", int'(last_fe[0]), 0);
    chk("t1_busy", int'(bz0), 0);

    // 2: 3-tick glitch, then 0x3C
    b_ds = ds_cnt[0]; b_fd = fd_cnt[0];
    drive(0, 1'b0, 12);
    drive(0, 1'b1, 200);
    chk("t2_glitch_shifts", ds_cnt[0] - b_ds, 0);
    chk("t2_glitch_done", fd_cnt[0] - b_fd, 0);
    chk("t2_glitch_busy", int'(bz0), 0);
    send(0, 8'h3C, 0, 0, 1, BIT_CLKS);
    repeat (40) @(negedge clk);
    chk("t2_shifts", ds_cnt[0] - b_ds, 8);
    chk("t2_bits", int'(cap[0]), int'(8'b0011_1100));
    chk("t2_done", fd_cnt[0] - b_fd, 1);

    // 3: 0x55, stop low held two bit times
    b_ds = ds_cnt[0]; b_fd = fd_cnt[0];
    send(0, 8'h55, 0, 0, 0, 2 * BIT_CLKS);
    chk("t3_done", fd_cnt[0] - b_fd, 1);
    chk("t3_ferr", int'(last_fe[0]), 1);
    chk("t3_busy_low", int'(bz0), 1);
    chk("t3_shifts_low", ds_cnt[0] - b_ds, 8);
    drive(0, 1'b1, 100);
    chk("t3_busy_after", int'(bz0), 0);
    chk("t3_no_restart", ds_cnt[0] - b_ds, 8);
    chk("t3_ferr_held", int'(fe0), 1);

    // 4: even parity instance, 0x07
    b_ds = ds_cnt[1];
    send(1, 8'h07, 1, 1, 1, BIT_CLKS);
    repeat (40) @(negedge clk);
    chk("t4a_perr", int'(last_pe[1]), 0);
    chk("t4a_shifts", ds_cnt[1] - b_ds, 8);
    send(1, 8'h07, 1, 0, 1, BIT_CLKS);
    repeat (40) @(negedge clk);
    chk("t4b_perr", int'(last_pe[1]), 1);
    chk("t4b_shifts", ds_cnt[1] - b_ds, 16);
    chk("t4b_bits", int'(cap[1]), int'(8'b1110_0000));
    chk("t4b_perr_held", int'(pe1), 1);

    // 5: reset after the 4th data_shift
    n = 0;
    fork
      send(0, 8'h96, 0, 0, 1, BIT_CLKS);
      begin
        for (int t = 0; t < 2000 && n < 4; t++) begin
          @(negedge clk);
          if (ds0) n++;
        end
        chk("t5_reached_4_shifts", n, 4);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_shift", int'(ds0), 0);   chk("t5_rst_busy", int'(bz0), 0);
        chk("t5_rst_done", int'(fd0), 0);    chk("t5_rst_ferr", int'(fe0), 0);
        chk("t5_rst_bit", int'(bo0), 0);     chk("t5_rst_perr", int'(pe1), 0);
        expq.delete();
        b_ds = ds_cnt[0]; b_fd = fd_cnt[0];
      end
    join
    chk("t5_no_shift_in_rst", ds_cnt[0] - b_ds, 0);
    chk("t5_no_done_in_rst", fd_cnt[0] - b_fd, 0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(0, 8'hC3, 0, 0, 1, BIT_CLKS);
    repeat (40) @(negedge clk);
    chk("t5_after_shifts", ds_cnt[0] - b_ds, 8);
    chk("t5_after_bits", int'(cap[0]), int'(8'b1100_0011));

    // 6: back-to-back 0xFF, 0x00
    b_ds = ds_cnt[0]; b_fd = fd_cnt[0];
    send(0, 8'hFF, 0, 0, 1, BIT_CLKS);
    send(0, 8'h00, 0, 0, 1, BIT_CLKS);
    repeat (40) @(negedge clk);
    chk("t6_shifts", ds_cnt[0] - b_ds, 16);
    chk("t6_done", fd_cnt[0] - b_fd, 2);
    chk("t6_ferr", int'(fe0), 0);

    chk("all_events_seen", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
